mdu_hilo: RTL and testbench
===========================

Name: mdu_hilo

Overview:
- Multiply/divide unit with the HI/LO register pair, located in the EX stage of the five-stage pipeline.
- Consumes the one-hot decode lines for mult, multu, div, divu, madd, mthi, mtlo, mfhi and mflo, plus the forwarded rs/rt operands.
- Produces a multi-cycle HI/LO result, a read-back value for mfhi/mflo, and start/busy signals that the hazard unit uses to stall D.

Parameters:
- MULT_CYCLES, 5, busy duration for mult, multu and madd.
- DIV_CYCLES, 10, busy duration for div and divu.
- CNT_W, 4, cycle-counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- mult, multu, div, divu, madd  in  1 each  start-class decode lines, valid in EX.
- mthi, mtlo, mfhi, mflo  in  1 each  HI/LO move decode lines, valid in EX.
- A  in  32  rs operand (forwarded).
- B  in  32  rt operand (forwarded).
- start  out  1  combinational; high when a start-class line is high and busy=0.
- busy  out  1  registered; high while an operation is in flight.
- HI  out  32  registered HI.
- LO  out  32  registered LO.
- hilo_out  out  32  combinational: HI when mfhi=1, else LO.

Behaviour:
- Reset (reset=0, asynchronous):
  - HI=0, LO=0, busy=0, counter=0, state=IDLE.
  - An in-flight result is discarded.
  - Applies immediately, independent of clk.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- IDLE -> RUN on a rising edge with start=1. On that edge:
  - The result is computed from A/B and latched into internal hi_tmp/lo_tmp.
  - counter is loaded with MULT_CYCLES-1 or DIV_CYCLES-1.
  - op_kind is latched.
- RUN: counter decrements each edge. On the edge where counter==0:
  - HI<=hi_tmp and LO<=lo_tmp, unless the op is a divide by zero.
  - State returns to IDLE.
- Latency:
  - busy is high for exactly MULT_CYCLES or DIV_CYCLES cycles.
  - The new HI/LO are visible in the cycle after busy falls.
- Arithmetic:
  - mult: {HI,LO} = signed A x signed B, 64-bit.
  - multu: {HI,LO} = unsigned A x unsigned B, 64-bit.
  - madd: {HI,LO} = {HI,LO} + signed A x signed B, mod 2^64. The HI/LO used are the values at the start edge.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - divu: unsigned quotient and remainder.
  - Divide by zero (div or divu with B==0): HI and LO stay unchanged; busy still runs DIV_CYCLES cycles.
- mthi/mtlo:
  - Write HI or LO from A on the rising edge, only when state=IDLE and start=0.
  - While busy=1 they are ignored; the hazard unit stalls them and the bench checks that they are ignored.
- Start-class op while busy=1: ignored, start=0, the in-flight op is unaffected.
- Simultaneous start-class lines (illegal decode): priority is mult > multu > div > divu > madd.
- mfhi/mflo:
  - hilo_out is a pure combinational read of the current registers.
  - While busy=1 it shows the old value; the hazard unit stalls the read.
- Counter wrap: the counter never underflows, because reaching 0 always exits RUN.

Decomposition:
- Shared package mdu_pkg holds:
  - enum op_kind_t: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD.
  - Constants MULT_CYCLES_DEF=5, DIV_CYCLES_DEF=10.
  - Encodings state_t: IDLE, RUN.
- One sub-module, mdu_arith: combinational 64-bit result from op_kind, A, B, HI, LO, plus a div0 flag.
- The top level holds the FSM, counter, temp registers and HI/LO.

Test Plan:
- mult, A=0xFFFFFFFF, B=0x00000002 -> start=1 that cycle, busy=1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu with the same operands -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- div, A=0xFFFFFFF9 (-7), B=2 -> busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; then divu with B=0 -> HI/LO unchanged after 10 busy cycles.
- mthi A=0x12345678, next cycle mfhi -> hilo_out=0x12345678; then mtlo A=1, madd A=3, B=4 -> after 5 cycles LO=0x0000000D, HI=0x12345678.
- Second mult and mtlo issued while busy=1 -> start=0, both ignored; the first op's result is committed alone.
- reset=0 asserted in cycle 4 of a div -> busy=0, HI=0, LO=0 immediately; after release, a new mult with A=3, B=5 -> LO=15.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit and its HI/LO pair.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT,
    OP_MULTU,
    OP_DIV,
    OP_DIVU,
    OP_MADD
  } op_kind_t;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic op_is_div(input op_kind_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit {HI,LO} result for one mult/multu/div/divu/madd operation.
// Signed divide works on magnitudes so 0x80000000 / -1 stays well defined.
module mdu_arith
  import mdu_pkg::*;
(
  input  op_kind_t    op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [63:0] result_o,
  output logic        div0_o
);

  logic [63:0] a_sx, b_sx, a_zx, b_zx;
  logic [63:0] prod_s, prod_u;
  logic [31:0] b_safe, a_mag, b_mag;
  logic [31:0] num, den, q_raw, r_raw, q_s, r_s;
  logic        is_signed_div;

  always_comb begin
    a_sx   = {{32{a_i[31]}}, a_i};
    b_sx   = {{32{b_i[31]}}, b_i};
    a_zx   = {32'd0, a_i};
    b_zx   = {32'd0, b_i};
    prod_s = a_sx * b_sx;
    prod_u = a_zx * b_zx;

    div0_o = op_is_div(op_i) && (b_i == 32'd0);

    // A zero divisor is replaced by 1 so the divider never produces X; the
    // result is discarded in that case anyway.
    b_safe = (b_i == 32'd0) ? 32'd1 : b_i;
    a_mag  = a_i[31] ? (~a_i + 32'd1) : a_i;
    b_mag  = b_safe[31] ? (~b_safe + 32'd1) : b_safe;

    is_signed_div = (op_i == OP_DIV);
    num   = is_signed_div ? a_mag : a_i;
    den   = is_signed_div ? b_mag : b_safe;
    q_raw = num / den;
    r_raw = num % den;

    q_s = (a_i[31] ^ b_safe[31]) ? (~q_raw + 32'd1) : q_raw;
    r_s = a_i[31] ? (~r_raw + 32'd1) : r_raw;

    result_o = 64'd0;
    case (op_i)
      OP_MULT:  result_o = prod_s;
      OP_MULTU: result_o = prod_u;
      OP_DIV:   result_o = {r_s, q_s};
      OP_DIVU:  result_o = {r_raw, q_raw};
      OP_MADD:  result_o = {hi_i, lo_i} + prod_s;
      default:  result_o = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu_hilo.sv
// EX-stage multiply/divide unit: result computed at the start edge, held in temp
// registers, and committed to HI/LO when the busy countdown expires.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mult,
  input  logic        multu,
  input  logic        div,
  input  logic        divu,
  input  logic        madd,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic        mfhi,
  input  logic        mflo,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] hilo_out
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  op_kind_t           op_q, op_d, op_sel;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic [31:0]        hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;
  logic               div0_q, div0_d;
  logic               any_start;
  logic [63:0]        arith_res;
  logic               arith_div0;

  // Illegal multi-hot decode resolves as mult > multu > div > divu > madd.
  always_comb begin
    any_start = mult | multu | div | divu | madd;
    op_sel    = OP_MADD;
    if (mult)       op_sel = OP_MULT;
    else if (multu) op_sel = OP_MULTU;
    else if (div)   op_sel = OP_DIV;
    else if (divu)  op_sel = OP_DIVU;
  end

  mdu_arith u_arith (
    .op_i     (op_sel),
    .a_i      (A),
    .b_i      (B),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .result_o (arith_res),
    .div0_o   (arith_div0)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_tmp_d = hi_tmp_q;
    lo_tmp_d = lo_tmp_q;
    div0_d   = div0_q;
    start    = 1'b0;

    case (state_q)
      IDLE: begin
        start = any_start;
        if (any_start) begin
          state_d  = RUN;
          op_d     = op_sel;
          hi_tmp_d = arith_res[63:32];
          lo_tmp_d = arith_res[31:0];
          div0_d   = arith_div0;
          cnt_d    = op_is_div(op_sel) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
        end else begin
          if (mthi) hi_d = A;
          if (mtlo) lo_d = A;
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          if (!(div0_q && op_is_div(op_q))) begin
            hi_d = hi_tmp_q;
            lo_d = lo_tmp_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MULT;
      hi_q     <= '0;
      lo_q     <= '0;
      hi_tmp_q <= '0;
      lo_tmp_q <= '0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
      div0_q   <= div0_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign HI       = hi_q;
  assign LO       = lo_q;
  assign hilo_out = mfhi ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo: arithmetic results, busy duration, HI/LO moves,
// ignored ops while busy, and asynchronous reset during a divide.
module tb_mdu_hilo;

  logic        clk = 1'b0;
  logic        reset;
  logic        mult, multu, div, divu, madd, mthi, mtlo, mfhi, mflo;
  logic [31:0] A, B;
  wire         start, busy;
  wire  [31:0] HI, LO, hilo_out;

  int checks   = 0;
  int failures = 0;

  localparam logic [4:0] L_MULT  = 5'b10000;
  localparam logic [4:0] L_MULTU = 5'b01000;
  localparam logic [4:0] L_DIV   = 5'b00100;
  localparam logic [4:0] L_DIVU  = 5'b00010;
  localparam logic [4:0] L_MADD  = 5'b00001;

  always #5 clk = ~clk;

  mdu_hilo dut (
    .clk(clk), .reset(reset),
    .mult(mult), .multu(multu), .div(div), .divu(divu), .madd(madd),
    .mthi(mthi), .mtlo(mtlo), .mfhi(mfhi), .mflo(mflo),
    .A(A), .B(B),
    .start(start), .busy(busy), .HI(HI), .LO(LO), .hilo_out(hilo_out)
  );

  task automatic clear_lines();
    {mult, multu, div, divu, madd} = 5'b0;
    {mthi, mtlo, mfhi, mflo}       = 4'b0;
  endtask

  task automatic drive_op(input logic [4:0] ops, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    clear_lines();
    {mult, multu, div, divu, madd} = ops;
    A = a;
    B = b;
    #1;
  endtask

  // Counts busy cycles after the start edge; ends on a negedge with busy low.
  task automatic wait_idle(output int n);
    n = 0;
    @(negedge clk);
    clear_lines();
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    clear_lines();
    A = 32'd0; B = 32'd0;
    reset = 1'b0;
    #12;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (HI !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=0", HI); end
    checks++; if (LO !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=0", LO); end
    checks++; if (start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", start); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_mult();
    int n;
    drive_op(L_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
    checks++; if (start !== 1'b1) begin failures++; $display("FAIL mult_start got=%b exp=1", start); end
    wait_idle(n);
    checks++; if (n != 5) begin failures++; $display("FAIL mult_busy_cycles got=%0d exp=5", n); end
    checks++; if (HI !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", HI); end
    checks++; if (LO !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mult_lo got=%h exp=fffffffe", LO); end
  endtask

  task automatic test_multu();
    int n;
    drive_op(L_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
    wait_idle(n);
    checks++; if (n != 5) begin failures++; $display("FAIL multu_busy_cycles got=%0d exp=5", n); end
    checks++; if (HI !== 32'h0000_0001) begin failures++; $display("FAIL multu_hi got=%h exp=00000001", HI); end
    checks++; if (LO !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_lo got=%h exp=fffffffe", LO); end
  endtask

  task automatic test_priority();
    int n;
    // mult and multu together: signed mult wins, so HI is sign-filled.
    drive_op(L_MULT | L_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
    wait_idle(n);
    checks++; if (HI !== 32'hFFFF_FFFF) begin failures++; $display("FAIL prio_hi got=%h exp=ffffffff", HI); end
    checks++; if (n != 5) begin failures++; $display("FAIL prio_busy_cycles got=%0d exp=5", n); end
  endtask

  task automatic test_div();
    int n;
    drive_op(L_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_idle(n);
    checks++; if (n != 10) begin failures++; $display("FAIL div_busy_cycles got=%0d exp=10", n); end
    checks++; if (LO !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_lo got=%h exp=fffffffd", LO); end
    checks++; if (HI !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_hi got=%h exp=ffffffff", HI); end

    drive_op(L_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    checks++; if (LO !== 32'h8000_0000) begin failures++; $display("FAIL div_ovf_lo got=%h exp=80000000", LO); end
    checks++; if (HI !== 32'h0000_0000) begin failures++; $display("FAIL div_ovf_hi got=%h exp=00000000", HI); end

    drive_op(L_DIVU, 32'h0000_0064, 32'h0000_0000);
    wait_idle(n);
    checks++; if (n != 10) begin failures++; $display("FAIL div0_busy_cycles got=%0d exp=10", n); end
    checks++; if (LO !== 32'h8000_0000) begin failures++; $display("FAIL div0_lo got=%h exp=80000000", LO); end
    checks++; if (HI !== 32'h0000_0000) begin failures++; $display("FAIL div0_hi got=%h exp=00000000", HI); end

    drive_op(L_DIVU, 32'h0000_0064, 32'h0000_0007);
    wait_idle(n);
    checks++; if (LO !== 32'h0000_000E) begin failures++; $display("FAIL divu_lo got=%h exp=0000000e", LO); end
    checks++; if (HI !== 32'h0000_0002) begin failures++; $display("FAIL divu_hi got=%h exp=00000002", HI); end
  endtask

  task automatic test_moves_madd();
    int n;
    @(negedge clk);
    clear_lines();
    mthi = 1'b1; A = 32'h1234_5678;
    @(negedge clk);
    clear_lines();
    mfhi = 1'b1;
    #1;
    checks++; if (hilo_out !== 32'h1234_5678) begin failures++; $display("FAIL mfhi_read got=%h exp=12345678", hilo_out); end
    mfhi = 1'b0; mflo = 1'b1;
    #1;
    checks++; if (hilo_out !== 32'h0000_000E) begin failures++; $display("FAIL mflo_read got=%h exp=0000000e", hilo_out); end
    @(negedge clk);
    clear_lines();
    mtlo = 1'b1; A = 32'h0000_0001;
    drive_op(L_MADD, 32'h0000_0003, 32'h0000_0004);
    wait_idle(n);
    checks++; if (n != 5) begin failures++; $display("FAIL madd_busy_cycles got=%0d exp=5", n); end
    checks++; if (LO !== 32'h0000_000D) begin failures++; $display("FAIL madd_lo got=%h exp=0000000d", LO); end
    checks++; if (HI !== 32'h1234_5678) begin failures++; $display("FAIL madd_hi got=%h exp=12345678", HI); end

    // Negative product borrows from the accumulated value.
    drive_op(L_MADD, 32'hFFFF_FFFF, 32'h0000_0001);
    wait_idle(n);
    checks++; if (LO !== 32'h0000_000C) begin failures++; $display("FAIL madd_neg_lo got=%h exp=0000000c", LO); end
    checks++; if (HI !== 32'h1234_5678) begin failures++; $display("FAIL madd_neg_hi got=%h exp=12345678", HI); end
  endtask

  task automatic test_busy_ignore();
    int n;
    drive_op(L_MULT, 32'h0000_0002, 32'h0000_0003);
    @(negedge clk);
    clear_lines();
    n = 1;
    mult = 1'b1; mtlo = 1'b1; mflo = 1'b1;
    A = 32'h0000_0064; B = 32'h0000_0064;
    #1;
    checks++; if (start !== 1'b0) begin failures++; $display("FAIL busy_start got=%b exp=0", start); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_flag got=%b exp=1", busy); end
    checks++; if (hilo_out !== 32'h0000_000C) begin failures++; $display("FAIL busy_mflo_old got=%h exp=0000000c", hilo_out); end
    @(negedge clk);
    clear_lines();
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    checks++; if (n != 5) begin failures++; $display("FAIL busy_ignore_cycles got=%0d exp=5", n); end
    checks++; if (LO !== 32'h0000_0006) begin failures++; $display("FAIL busy_ignore_lo got=%h exp=00000006", LO); end
    checks++; if (HI !== 32'h0000_0000) begin failures++; $display("FAIL busy_ignore_hi got=%h exp=00000000", HI); end
  endtask

  task automatic test_reset_mid_div();
    int n;
    drive_op(L_DIV, 32'h0000_0064, 32'h0000_0007);
    @(negedge clk);
    clear_lines();
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_mid_busy_before got=%b exp=1", busy); end
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    checks++; if (HI !== 32'd0) begin failures++; $display("FAIL rst_mid_hi got=%h exp=0", HI); end
    checks++; if (LO !== 32'd0) begin failures++; $display("FAIL rst_mid_lo got=%h exp=0", LO); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_released_busy got=%b exp=0", busy); end
    drive_op(L_MULT, 32'h0000_0003, 32'h0000_0005);
    checks++; if (start !== 1'b1) begin failures++; $display("FAIL rst_mid_restart got=%b exp=1", start); end
    wait_idle(n);
    checks++; if (n != 5) begin failures++; $display("FAIL rst_mid_mult_cycles got=%0d exp=5", n); end
    checks++; if (LO !== 32'd15) begin failures++; $display("FAIL rst_mid_mult_lo got=%h exp=0000000f", LO); end
    checks++; if (HI !== 32'd0) begin failures++; $display("FAIL rst_mid_mult_hi got=%h exp=00000000", HI); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_priority();
    test_div();
    test_moves_madd();
    test_busy_ignore();
    test_reset_mid_div();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
